bcd_serial_adder: RTL and testbench
===================================

BCD_SERIAL_ADDER -- requirements
Module: bcd_serial_adder

Interface
REQ-001 SHALL provide parameter NDIG, default 4, meaning the number of BCD digits per operand (legal values 1..8).
REQ-002 SHALL provide port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL provide port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL provide port start, input, 1 bit: request to begin an addition; sampled on the rising edge.
REQ-005 SHALL provide port a, input, 4*NDIG bits: operand A as packed BCD, digit 0 in bits [3:0].
REQ-006 SHALL provide port b, input, 4*NDIG bits: operand B as packed BCD.
REQ-007 SHALL provide port cin, input, 1 bit: decimal carry-in to digit 0.
REQ-008 SHALL provide port busy, output, 1 bit: high while the addition is in progress.
REQ-009 SHALL provide port done, output, 1 bit: one-cycle pulse marking the result as valid.
REQ-010 SHALL provide port sum, output, 4*NDIG bits: registered packed-BCD result.
REQ-011 SHALL provide port cout, output, 1 bit: decimal carry-out of the most significant digit.
REQ-012 SHALL provide port err, output, 1 bit: high when any latched operand digit is greater than 9.

Function
REQ-013 SHALL implement an FSM with three states: IDLE, ADD and DONE.
REQ-014 SHALL accept start only in IDLE or DONE (busy=0); start in ADD SHALL be ignored with no effect.
REQ-015 On an accepted start, SHALL latch a, b and cin, set the digit index to 0, clear the working carry to cin, and enter ADD.
REQ-016 In ADD, SHALL process exactly one digit i per cycle: z = a_i + b_i + c, computed at 5-bit width.
REQ-017 If z > 9, SHALL produce digit (z+6) mod 16 and next carry 1; otherwise SHALL produce digit z and next carry 0.
REQ-018 SHALL write each digit into an internal working register, with the index incrementing from 0 to NDIG-1 and no wrap.
REQ-019 After digit NDIG-1, SHALL enter DONE, copy the working register to sum and the final carry to cout, and assert done for exactly that one cycle.
REQ-020 SHALL go from DONE to IDLE on the next edge, unless start is accepted, in which case it SHALL go to ADD.
REQ-021 SHALL hold sum and cout stable from DONE until the next DONE; they SHALL NOT change during ADD.
REQ-022 SHALL hold busy at 1 exactly in ADD.
REQ-023 Latency: start accepted at edge t -> done high in the cycle after edge t+NDIG, i.e. NDIG+1 edges.
REQ-024 SHALL latch err at an accepted start as the OR of (digit > 9) over all digits of a and b, and hold it until the next accepted start.
REQ-025 When err is high, the digit rule of REQ-017 SHALL still apply, with no saturation and no abort.
REQ-026 SHALL ignore input changes on a and b after acceptance until the next accepted start.

Reset
REQ-027 rst_n low SHALL immediately force the FSM to IDLE and busy, done, cout and err to 0, with sum and all internal registers cleared to 0, from any state.
REQ-028 Reset asserted during ADD SHALL discard the partial result; no done pulse SHALL follow.
REQ-029 After rst_n rises, the first start SHALL be accepted on the first rising edge where it is sampled high.

Verification
REQ-030 NDIG=4, a=0x1234, b=0x5678, cin=0 -> sum=0x6912, cout=0, err=0; done exactly 5 edges after start; busy high for 4 cycles.
REQ-031 a=0x9999, b=0x0001, cin=0 -> sum=0x0000, cout=1; a=0x9999, b=0x9999, cin=1 -> sum=0x9999, cout=1.
REQ-032 Start re-pulsed with a=0x1111 during ADD of an addition of 0x0005+0x0005 -> result sum=0x0010, single done pulse; a new start in the DONE cycle is accepted and busy rises on the next edge.
REQ-033 rst_n low while digit 2 is being processed -> all outputs 0 asynchronously, no done pulse; a subsequent 0x0001+0x0001 -> sum=0x0002.
REQ-034 a=0x00A0, b=0x0000, cin=0 -> err=1, sum=0x0100, cout=0; err clears on the next start with valid operands.
REQ-035 Random legal BCD operands and cin (1000 or more runs, NDIG=4 and NDIG=1) -> sum and cout match the decimal reference model; done latency always NDIG+1.

Source files
------------

// File: rtl/bcd_serial_adder.sv
// Digit-serial packed-BCD adder: one decimal digit per clock, least significant
// digit first, result and carry-out registered at the end of the pass.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for start; sum/cout/err hold the last result
// ADD   | processing digit idx of the latched operands, busy=1
// DONE  | result just copied to sum/cout, done=1 for this cycle
module bcd_serial_adder #(
  parameter int NDIG = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [4*NDIG-1:0] a,
  input  logic [4*NDIG-1:0] b,
  input  logic              cin,
  output logic              busy,
  output logic              done,
  output logic [4*NDIG-1:0] sum,
  output logic              cout,
  output logic              err
);

  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t            state, state_nxt;
  logic [4*NDIG-1:0] a_q, b_q, work, work_nxt;
  logic              carry, carry_nxt;
  logic [IW-1:0]     idx;
  logic              accept, last, op_err;
  logic [3:0]        a_dig, b_dig, dig;
  logic [4:0]        z, z_adj;

  // start is only honoured when no addition is running
  assign accept = start && (state != ADD);
  assign last   = (idx == IW'(NDIG - 1));

  // one BCD digit step: binary add, then +6 correction when above 9
  always_comb begin
    a_dig     = a_q[idx*4 +: 4];
    b_dig     = b_q[idx*4 +: 4];
    z         = {1'b0, a_dig} + {1'b0, b_dig} + {4'b0000, carry};
    z_adj     = z + 5'd6;
    if (z > 5'd9) begin
      dig       = z_adj[3:0];
      carry_nxt = 1'b1;
    end else begin
      dig       = z[3:0];
      carry_nxt = 1'b0;
    end
    work_nxt             = work;
    work_nxt[idx*4 +: 4] = dig;
  end

  // flag any non-BCD digit on the live operand inputs (latched on accept)
  always_comb begin
    op_err = 1'b0;
    for (int i = 0; i < NDIG; i++) begin
      if ((a[4*i +: 4] > 4'd9) || (b[4*i +: 4] > 4'd9)) op_err = 1'b1;
    end
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ADD;
      ADD:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = start ? ADD : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // outputs decoded from state
  always_comb begin
    busy = (state == ADD);
    done = (state == DONE);
  end

  // operand latch, digit walk and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      work  <= '0;
      carry <= 1'b0;
      idx   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      err   <= 1'b0;
    end else if (accept) begin
      a_q   <= a;
      b_q   <= b;
      work  <= '0;
      carry <= cin;
      idx   <= '0;
      err   <= op_err;
    end else if (state == ADD) begin
      work  <= work_nxt;
      carry <= carry_nxt;
      if (last) begin
        // final digit goes straight into sum so it is valid with done
        sum  <= work_nxt;
        cout <= carry_nxt;
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Directed and random checks of bcd_serial_adder at NDIG=4 and NDIG=1.
module tb_bcd_serial_adder;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        start4, cin4, busy4, done4, cout4, err4;
  logic [15:0] a4, b4, sum4;
  logic        start1, cin1, busy1, done1, cout1, err1;
  logic [3:0]  a1, b1, sum1;

  int errors = 0;
  int checks = 0;

  bcd_serial_adder #(.NDIG(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .cin(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .err(err4)
  );

  bcd_serial_adder #(.NDIG(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .err(err1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int bcd_to_int(input logic [15:0] v);
    int r = 0;
    for (int i = 3; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [15:0] int_to_bcd(input int v);
    logic [15:0] r = '0;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // drive operands with start high across one edge; returns #1 after that edge
  task automatic go4(input logic [15:0] a, input logic [15:0] b, input logic c);
    a4 = a; b4 = b; cin4 = c; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
  endtask

  // edges counted from the accepting edge (=1) up to the one that raised done
  task automatic wait_done4(output int lat, output int bcnt);
    lat = 1; bcnt = 0;
    for (int k = 0; k < 20; k++) begin
      if (done4) break;
      if (busy4) bcnt++;
      @(posedge clk); #1;
      lat++;
    end
    if (!done4) check("timeout4", 32'd0, 32'd1);
  endtask

  task automatic add4(input logic [15:0] a, input logic [15:0] b, input logic c,
                      input logic [15:0] es, input logic ec, input string tag);
    int lat, bcnt;
    go4(a, b, c);
    wait_done4(lat, bcnt);
    check({tag, "_sum"}, sum4, es);
    check({tag, "_cout"}, cout4, ec);
    check({tag, "_lat"}, lat, 5);
  endtask

  task automatic add1(input logic [3:0] a, input logic [3:0] b, input logic c,
                      input logic [3:0] es, input logic ec);
    int lat;
    a1 = a; b1 = b; cin1 = c; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    lat = 1;
    for (int k = 0; k < 10; k++) begin
      if (done1) break;
      @(posedge clk); #1;
      lat++;
    end
    check("rnd1_sum", sum1, es);
    check("rnd1_cout", cout1, ec);
    check("rnd1_lat", lat, 2);
  endtask

  initial begin
    int lat, bcnt, dcnt;
    logic [15:0] ra, rb, es;
    logic        rc;
    int          tot;

    rst_n = 1'b0;
    start4 = 0; a4 = '0; b4 = '0; cin4 = 0;
    start1 = 0; a1 = '0; b1 = '0; cin1 = 0;
    #1;
    check("rst_busy", busy4, 0);
    check("rst_done", done4, 0);
    check("rst_sum", sum4, 0);
    check("rst_cout", cout4, 0);
    check("rst_err", err4, 0);
    #21 rst_n = 1'b1;
    @(posedge clk); #1;

    // basic addition with latency and busy width
    go4(16'h1234, 16'h5678, 1'b0);
    wait_done4(lat, bcnt);
    check("b_sum", sum4, 16'h6912);
    check("b_cout", cout4, 0);
    check("b_err", err4, 0);
    check("b_lat", lat, 5);
    check("b_busy", bcnt, 4);
    @(posedge clk); #1;
    check("b_done_pulse", done4, 0);

    add4(16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, "c9");
    add4(16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1, "c99");

    // start during ADD must be ignored; sum holds during ADD
    @(posedge clk); #1;
    go4(16'h0005, 16'h0005, 1'b0);
    a4 = 16'h1111; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    check("ign_busy", busy4, 1);
    check("ign_sum_hold", sum4, 16'h9999);
    dcnt = 0;
    for (int k = 0; k < 10; k++) begin
      if (done4) dcnt++;
      if (dcnt == 0) begin @(posedge clk); #1; end
      else break;
    end
    check("ign_sum", sum4, 16'h0010);
    check("ign_cout", cout4, 0);
    // start in the DONE cycle is accepted immediately
    go4(16'h0001, 16'h0002, 1'b0);
    check("done_acc_busy", busy4, 1);
    for (int k = 0; k < 8; k++) begin
      if (done4) dcnt++;
      @(posedge clk); #1;
    end
    check("ign_done_cnt", dcnt, 2);
    check("done_acc_sum", sum4, 16'h0003);

    // reset while digit 2 is being processed
    go4(16'h12A4, 16'h1111, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("pre_rst_err", err4, 1);
    rst_n = 1'b0;
    #1;
    check("arst_busy", busy4, 0);
    check("arst_sum", sum4, 0);
    check("arst_cout", cout4, 0);
    check("arst_err", err4, 0);
    @(posedge clk); #4;
    rst_n = 1'b1;
    @(posedge clk); #1;
    dcnt = 0;
    for (int k = 0; k < 6; k++) begin
      if (done4) dcnt++;
      @(posedge clk); #1;
    end
    check("arst_no_done", dcnt, 0);
    add4(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, "post_rst");

    // invalid digit still follows the digit rule and raises err
    add4(16'h00A0, 16'h0000, 1'b0, 16'h0100, 1'b0, "bad");
    check("bad_err", err4, 1);
    add4(16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, "good");
    check("good_err", err4, 0);

    // random legal operands against a decimal model
    for (int n = 0; n < 1000; n++) begin
      for (int i = 0; i < 4; i++) begin
        ra[4*i +: 4] = 4'($urandom_range(0, 9));
        rb[4*i +: 4] = 4'($urandom_range(0, 9));
      end
      rc  = 1'($urandom_range(0, 1));
      tot = bcd_to_int(ra) + bcd_to_int(rb) + int'(rc);
      es  = int_to_bcd(tot % 10000);
      add4(ra, rb, rc, es, tot >= 10000, "rnd4");
    end
    for (int n = 0; n < 1000; n++) begin
      ra[3:0] = 4'($urandom_range(0, 9));
      rb[3:0] = 4'($urandom_range(0, 9));
      rc      = 1'($urandom_range(0, 1));
      tot     = int'(ra[3:0]) + int'(rb[3:0]) + int'(rc);
      add1(ra[3:0], rb[3:0], rc, 4'(tot % 10), tot >= 10);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
